// File: rtl/router_pkg.sv
// Shared definitions for the virtual-channel XY mesh router: port indices,
// flit types, output arbiter states and the dimension-ordered route function.
package router_pkg;

  localparam int N_PORTS = 5;

  localparam logic [2:0] P_LOCAL = 3'd0;
  localparam logic [2:0] P_NORTH = 3'd1;
  localparam logic [2:0] P_EAST  = 3'd2;
  localparam logic [2:0] P_SOUTH = 3'd3;
  localparam logic [2:0] P_WEST  = 3'd4;

  typedef enum logic [1:0] {
    FT_BODY = 2'b00,
    FT_HEAD = 2'b01,
    FT_TAIL = 2'b10,
    FT_HT   = 2'b11
  } flit_type_e;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } out_state_e;

  // Width of a flattened (port,VC) grant index for a given VC count.
  function automatic int gnt_w(input int num_vc);
    return $clog2(N_PORTS * num_vc);
  endfunction

  // X is resolved before Y so that routes are deadlock-free on a mesh.
  function automatic logic [2:0] route_xy(input logic [7:0] dx, input logic [7:0] dy,
                                          input logic [7:0] mx, input logic [7:0] my);
    if (dx > mx)      return P_EAST;
    else if (dx < mx) return P_WEST;
    else if (dy > my) return P_NORTH;
    else if (dy < my) return P_SOUTH;
    else              return P_LOCAL;
  endfunction

endpackage

// File: rtl/router_vc_fifo.sv
// Per-(port,VC) flit FIFO with a fall-through front so the arbiter sees the
// head flit in the cycle after it is written.
module router_vc_fifo #(
  parameter  int DATA_W = 35,
  parameter  int DEPTH  = 4,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = AW + 1
) (
  input  logic              clk,
  input  logic              i_srst,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  output logic [DATA_W-1:0] o_rd_data,
  output logic [CW-1:0]     o_count,
  output logic              o_empty,
  output logic              o_full
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              w_wr;
  logic              w_rd;

  // Full is taken from the registered count, so a same-cycle read never frees room.
  assign w_wr      = i_wr_en && !o_full;
  assign w_rd      = i_rd_en && !o_empty;
  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_count   = r_count;
  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge clk) begin
    if (i_srst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_wr) - CW'(w_rd);
    end
  end

endmodule

// File: rtl/router_vc_xy.sv
// 5-port virtual-channel mesh router: per-VC input FIFOs, XY routing and a
// wormhole round-robin arbiter per output. Define ROUTER_ERR_EN for the ERR port.
module router_vc_xy
  import router_pkg::*;
#(
  parameter  int DATA_W  = 35,
  parameter  int NUM_VC  = 2,
  parameter  int DEPTH   = 4,
  parameter  int COORD_W = 2,
  localparam int VC_W    = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic                      clk,
  input  logic                      RST_,
  input  logic [5*DATA_W-1:0]       IDATA,
  input  logic [4:0]                IVALID,
  input  logic [5*VC_W-1:0]         IVCH,
  output logic [5*NUM_VC-1:0]       OACK,
  output logic [5*NUM_VC-1:0]       ORDY,
  output logic [5*NUM_VC-1:0]       OLCK,
  output logic [5*DATA_W-1:0]       ODATA,
  output logic [4:0]                OVALID,
  output logic [5*VC_W-1:0]         OVCH,
  input  logic [5*NUM_VC-1:0]       IACK,
  input  logic [5*NUM_VC-1:0]       ILCK,
  input  logic [COORD_W-1:0]        MY_XPOS,
  input  logic [COORD_W-1:0]        MY_YPOS
`ifdef ROUTER_ERR_EN
  ,
  output logic [4:0]                ERR
`endif
);

  localparam int NQ    = N_PORTS * NUM_VC;
  localparam int GNT_W = gnt_w(NUM_VC);
  localparam int CW    = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] w_front  [NQ];
  logic [CW-1:0]     w_count  [NQ];
  logic [2:0]        w_route  [NQ];
  logic [VC_W-1:0]   w_vc_of  [NQ];
  logic [NQ-1:0]     w_empty, w_full, w_try, w_wr, w_rd, w_head, w_locked, w_discard;
  logic [NQ-1:0]     r_oack;
  logic              w_unused;

  // Downstream lock status is informational only.
  assign w_unused = ^ILCK;

  for (genvar gi = 0; gi < NQ; gi++) begin : g_vc
    localparam int P = gi / NUM_VC;
    localparam int V = gi % NUM_VC;
    flit_type_e w_type;

    assign w_try[gi] = IVALID[P] && (IVCH[P*VC_W +: VC_W] == VC_W'(V));
    assign w_wr[gi]  = w_try[gi] && !w_full[gi] && !RST_;
    assign ORDY[gi]  = !RST_ && (w_count[gi] < CW'(DEPTH));

    router_vc_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .i_srst    (RST_),
      .i_wr_en   (w_wr[gi]),
      .i_wr_data (IDATA[P*DATA_W +: DATA_W]),
      .i_rd_en   (w_rd[gi]),
      .o_rd_data (w_front[gi]),
      .o_count   (w_count[gi]),
      .o_empty   (w_empty[gi]),
      .o_full    (w_full[gi])
    );

    assign w_type        = flit_type_e'(w_front[gi][DATA_W-1 -: 2]);
    assign w_head[gi]    = (w_type == FT_HEAD) || (w_type == FT_HT);
    assign w_route[gi]   = route_xy(8'(w_front[gi][2*COORD_W-1:COORD_W]),
                                    8'(w_front[gi][COORD_W-1:0]),
                                    8'(MY_XPOS), 8'(MY_YPOS));
    assign w_vc_of[gi]   = VC_W'(V);
    // Headless flits at an unlocked front can never be forwarded; drain them.
    assign w_discard[gi] = !w_empty[gi] && !w_head[gi] && !w_locked[gi];
  end

  for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_out
    out_state_e        r_state;
    logic [GNT_W-1:0]  r_src, r_last, w_rr, w_idx;
    logic [DATA_W-1:0] r_odata, w_flit;
    logic [VC_W-1:0]   r_ovch;
    logic              r_ovalid, w_found, w_snd, w_tail;
    logic [NQ-1:0]     w_req, w_iack_ok, w_hold, w_take;
    flit_type_e        w_ftype;

    for (genvar gj = 0; gj < NQ; gj++) begin : g_req
      assign w_iack_ok[gj] = IACK[gi*NUM_VC + (gj % NUM_VC)];
      assign w_req[gj]     = !w_empty[gj] && w_head[gj] && !w_locked[gj] &&
                             (w_route[gj] == 3'(gi)) && w_iack_ok[gj];
      assign w_hold[gj]    = (r_state == S_LOCKED) && (r_src == GNT_W'(gj));
      assign w_take[gj]    = w_snd && (w_idx == GNT_W'(gj));
    end

    // Round-robin: first requester above the last grant, then wrap from zero.
    always_comb begin
      w_found = 1'b0;
      w_rr    = '0;
      for (int j = 0; j < NQ; j++) begin
        if (!w_found && w_req[j] && (GNT_W'(j) > r_last)) begin
          w_found = 1'b1;
          w_rr    = GNT_W'(j);
        end
      end
      for (int j = 0; j < NQ; j++) begin
        if (!w_found && w_req[j] && (GNT_W'(j) <= r_last)) begin
          w_found = 1'b1;
          w_rr    = GNT_W'(j);
        end
      end
    end

    always_comb begin
      if (r_state == S_IDLE) begin
        w_idx = w_rr;
        w_snd = w_found;
      end else begin
        w_idx = r_src;
        w_snd = !w_empty[r_src] && w_iack_ok[r_src];
      end
    end

    assign w_flit  = w_front[w_idx];
    assign w_ftype = flit_type_e'(w_flit[DATA_W-1 -: 2]);
    assign w_tail  = (w_ftype == FT_TAIL) || (w_ftype == FT_HT);

    always_ff @(posedge clk) begin
      if (RST_) begin
        r_state  <= S_IDLE;
        r_src    <= '0;
        r_last   <= '0;
        r_odata  <= '0;
        r_ovalid <= 1'b0;
        r_ovch   <= '0;
      end else begin
        r_ovalid <= w_snd;
        r_odata  <= w_snd ? w_flit : '0;
        r_ovch   <= w_snd ? w_vc_of[w_idx] : '0;
        case (r_state)
          S_IDLE: begin
            if (w_found) begin
              r_last <= w_rr;
              if (!w_tail) begin
                r_state <= S_LOCKED;
                r_src   <= w_rr;
              end
            end
          end
          S_LOCKED: begin
            if (w_snd && w_tail) r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end

    assign ODATA[gi*DATA_W +: DATA_W] = r_odata;
    assign OVALID[gi]                 = r_ovalid;
    assign OVCH[gi*VC_W +: VC_W]      = r_ovch;
  end

  assign w_locked = g_out[0].w_hold | g_out[1].w_hold | g_out[2].w_hold |
                    g_out[3].w_hold | g_out[4].w_hold;
  assign w_rd     = g_out[0].w_take | g_out[1].w_take | g_out[2].w_take |
                    g_out[3].w_take | g_out[4].w_take | w_discard;
  assign OLCK     = w_locked;
  assign OACK     = r_oack;

  always_ff @(posedge clk) begin
    if (RST_) r_oack <= '0;
    else      r_oack <= w_wr;
  end

`ifdef ROUTER_ERR_EN
  logic [4:0] r_err;
  logic [4:0] w_err_set;

  for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_err
    logic w_bad_vc;
    assign w_bad_vc      = IVALID[gi] && (32'(IVCH[gi*VC_W +: VC_W]) >= NUM_VC);
    assign w_err_set[gi] = w_bad_vc ||
                           (|(w_try[gi*NUM_VC +: NUM_VC] & ~ORDY[gi*NUM_VC +: NUM_VC])) ||
                           (|w_discard[gi*NUM_VC +: NUM_VC]);
  end

  always_ff @(posedge clk) begin
    if (RST_) r_err <= '0;
    else      r_err <= r_err | w_err_set;
  end

  assign ERR = r_err;
`endif

endmodule

// File: tb/tb_router_vc_xy.sv
// Directed self-checking bench for router_vc_xy at mesh node (1,1).
module tb_router_vc_xy;
  import router_pkg::*;

  localparam int DATA_W  = 35;
  localparam int NUM_VC  = 2;
  localparam int DEPTH   = 4;
  localparam int COORD_W = 2;
  localparam int VC_W    = 1;

  logic                  clk = 1'b0;
  logic                  RST_;
  logic [5*DATA_W-1:0]   IDATA;
  logic [4:0]            IVALID;
  logic [5*VC_W-1:0]     IVCH;
  logic [5*NUM_VC-1:0]   OACK, ORDY, OLCK, IACK, ILCK;
  logic [5*DATA_W-1:0]   ODATA;
  logic [4:0]            OVALID;
  logic [5*VC_W-1:0]     OVCH;
  logic [COORD_W-1:0]    MY_XPOS, MY_YPOS;
`ifdef ROUTER_ERR_EN
  logic [4:0]            ERR;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  router_vc_xy #(.DATA_W(DATA_W), .NUM_VC(NUM_VC), .DEPTH(DEPTH), .COORD_W(COORD_W)) dut (
    .clk(clk), .RST_(RST_), .IDATA(IDATA), .IVALID(IVALID), .IVCH(IVCH),
    .OACK(OACK), .ORDY(ORDY), .OLCK(OLCK), .ODATA(ODATA), .OVALID(OVALID), .OVCH(OVCH),
    .IACK(IACK), .ILCK(ILCK), .MY_XPOS(MY_XPOS), .MY_YPOS(MY_YPOS)
`ifdef ROUTER_ERR_EN
    , .ERR(ERR)
`endif
  );

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("[%0t] %s observed=%h expected=%h", $time, tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] mk(input logic [1:0] t, input int pay,
                                           input logic [1:0] dx, input logic [1:0] dy);
    return {t, 29'(pay), dx, dy};
  endfunction

  task automatic drive(input int p, input logic [VC_W-1:0] v, input logic [DATA_W-1:0] f);
    IDATA[p*DATA_W +: DATA_W] = f;
    IVALID[p]                 = 1'b1;
    IVCH[p*VC_W +: VC_W]      = v;
  endtask

  function automatic logic [DATA_W-1:0] od(input int p);
    return ODATA[p*DATA_W +: DATA_W];
  endfunction

  logic [DATA_W-1:0] f_h, f_b, f_b2, f_t, f_a1, f_a3, f_a4;

  initial begin
    RST_ = 1'b1; IDATA = '0; IVALID = '0; IVCH = '0;
    IACK = '1; ILCK = '0; MY_XPOS = 2'd1; MY_YPOS = 2'd1;

    // Reset state
    tick(); tick();
    chk("rst_ovalid", 35'(OVALID), 35'(5'b0));
    chk("rst_odata",  od(2), '0);
    chk("rst_oack",   35'(OACK), 35'(10'b0));
    chk("rst_olck",   35'(OLCK), 35'(10'b0));
    chk("rst_ordy",   35'(ORDY), 35'(10'b0));
    RST_ = 1'b0;
    tick();
    chk("rel_ordy",   35'(ORDY), 35'(10'h3ff));

    // 3-flit packet, port 0 VC1 -> dest (2,1) -> east
    f_h = mk(FT_HEAD, 11, 2'd2, 2'd1); f_b = mk(FT_BODY, 12, 2'd2, 2'd1); f_t = mk(FT_TAIL, 13, 2'd2, 2'd1);
    drive(0, 1'b1, f_h); tick();
    chk("p1_oack_h",  35'(OACK), 35'(10'b0000000010));
    chk("p1_ovalid0", 35'(OVALID), 35'(5'b0));
    drive(0, 1'b1, f_b); tick();
    chk("p1_oack_b",  35'(OACK), 35'(10'b0000000010));
    chk("p1_ovalid1", 35'(OVALID), 35'(5'b00100));
    chk("p1_head",    od(2), f_h);
    chk("p1_ovch",    35'(OVCH), 35'(5'b00100));
    chk("p1_olck1",   35'(OLCK), 35'(10'b0000000010));
    drive(0, 1'b1, f_t); tick();
    chk("p1_oack_t",  35'(OACK), 35'(10'b0000000010));
    chk("p1_body",    od(2), f_b);
    chk("p1_olck2",   35'(OLCK), 35'(10'b0000000010));
    IVALID = '0; tick();
    chk("p1_tail",    od(2), f_t);
    chk("p1_ovalid3", 35'(OVALID), 35'(5'b00100));
    chk("p1_olck3",   35'(OLCK), 35'(10'b0));
    chk("p1_oack_0",  35'(OACK), 35'(10'b0));
    tick();
    chk("p1_ovalid4", 35'(OVALID), 35'(5'b0));

    // Round robin on local output: ports 1,3,4 (indices 2,6,8)
    f_a1 = mk(FT_HT, 21, 2'd1, 2'd1); f_a3 = mk(FT_HT, 23, 2'd1, 2'd1); f_a4 = mk(FT_HT, 24, 2'd1, 2'd1);
    drive(1, 1'b0, f_a1); drive(3, 1'b0, f_a3); drive(4, 1'b0, f_a4); tick();
    chk("rr1_oack",   35'(OACK), 35'(10'b0101000100));
    IVALID = '0; tick();
    chk("rr1_v0",     35'(OVALID), 35'(5'b00001));
    chk("rr1_g0",     od(0), f_a1);
    tick(); chk("rr1_g1", od(0), f_a3);
    tick(); chk("rr1_g2", od(0), f_a4);
    chk("rr1_ovch",   35'(OVCH), 35'(5'b0));
    tick(); chk("rr1_idle", 35'(OVALID), 35'(5'b0));
    // Second burst: wraps past index 8, ports 1 then 3; last grant becomes 6
    f_a1 = mk(FT_HT, 31, 2'd1, 2'd1); f_a3 = mk(FT_HT, 33, 2'd1, 2'd1);
    drive(1, 1'b0, f_a1); drive(3, 1'b0, f_a3); tick();
    IVALID = '0; tick();
    chk("rr2_g0",     od(0), f_a1);
    tick(); chk("rr2_g1", od(0), f_a3);
    tick(); chk("rr2_idle", 35'(OVALID), 35'(5'b0));
    // Third burst: ports 1 and 4; after last grant 6 port 4 (index 8) wins first
    f_a1 = mk(FT_HT, 41, 2'd1, 2'd1); f_a4 = mk(FT_HT, 44, 2'd1, 2'd1);
    drive(1, 1'b0, f_a1); drive(4, 1'b0, f_a4); tick();
    IVALID = '0; tick();
    chk("rr3_g0",     od(0), f_a4);
    tick(); chk("rr3_g1", od(0), f_a1);
    tick(); chk("rr3_idle", 35'(OVALID), 35'(5'b0));

    // Backpressure: IACK_2[0] low during locked packet from port 0 VC0
    f_h = mk(FT_HEAD, 51, 2'd2, 2'd0); f_b = mk(FT_BODY, 52, 2'd2, 2'd0);
    f_b2 = mk(FT_BODY, 53, 2'd2, 2'd0); f_t = mk(FT_TAIL, 54, 2'd2, 2'd0);
    drive(0, 1'b0, f_h); tick();
    drive(0, 1'b0, f_b); tick();
    chk("bp_head",    od(2), f_h);
    IACK[4] = 1'b0;
    drive(0, 1'b0, f_b2); tick();
    chk("bp_stall1",  35'(OVALID), 35'(5'b0));
    chk("bp_lock1",   35'(OLCK), 35'(10'b0000000001));
    drive(0, 1'b0, f_t); tick();
    chk("bp_stall2",  35'(OVALID), 35'(5'b0));
    chk("bp_lock2",   35'(OLCK), 35'(10'b0000000001));
    IVALID = '0; IACK[4] = 1'b1; tick();
    chk("bp_body1",   od(2), f_b);
    chk("bp_v1",      35'(OVALID), 35'(5'b00100));
    tick(); chk("bp_body2", od(2), f_b2);
    tick(); chk("bp_tail",  od(2), f_t);
    tick();
    chk("bp_idle",    35'(OVALID), 35'(5'b0));
    chk("bp_unlock",  35'(OLCK), 35'(10'b0));

    // Overflow: DEPTH+1 writes to port 3 VC0 with east output blocked
    IACK[4] = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      drive(3, 1'b0, mk((i == 0) ? FT_HEAD : FT_BODY, 60 + i, 2'd2, 2'd1));
      tick();
      chk($sformatf("ovf_oack%0d", i), 35'(OACK[6]), 35'((i < DEPTH) ? 1 : 0));
      chk($sformatf("ovf_ordy%0d", i), 35'(ORDY[6]), 35'((i < DEPTH - 1) ? 1 : 0));
    end
    chk("ovf_noout",  35'(OVALID), 35'(5'b0));
`ifdef ROUTER_ERR_EN
    chk("ovf_err",    35'(ERR), 35'(5'b01000));
`endif
    IVALID = '0; RST_ = 1'b1; tick();
    RST_ = 1'b0; IACK = '1; tick();

    // Headless body flit on port 1 VC0 is discarded
    drive(1, 1'b0, mk(FT_BODY, 70, 2'd1, 2'd1)); tick();
    chk("hl_oack",    35'(OACK), 35'(10'b0000000100));
    IVALID = '0; tick();
    chk("hl_noout1",  35'(OVALID), 35'(5'b0));
`ifdef ROUTER_ERR_EN
    chk("hl_err",     35'(ERR), 35'(5'b00010));
`endif
    tick();
    chk("hl_noout2",  35'(OVALID), 35'(5'b0));
    f_a1 = mk(FT_HT, 71, 2'd1, 2'd1);
    drive(1, 1'b0, f_a1); tick();
    IVALID = '0; tick();
    chk("hl_next",    od(0), f_a1);
    chk("hl_nextv",   35'(OVALID), 35'(5'b00001));
    tick();

    // Reset mid-packet
    f_h = mk(FT_HEAD, 81, 2'd2, 2'd1); f_b = mk(FT_BODY, 82, 2'd2, 2'd1);
    drive(0, 1'b1, f_h); tick();
    drive(0, 1'b1, f_b); tick();
    chk("mr_v",       35'(OVALID), 35'(5'b00100));
    chk("mr_lock",    35'(OLCK), 35'(10'b0000000010));
    RST_ = 1'b1; tick();
    chk("mr_ovalid",  35'(OVALID), 35'(5'b0));
    chk("mr_odata",   od(2), '0);
    chk("mr_ovch",    35'(OVCH), 35'(5'b0));
    chk("mr_oack",    35'(OACK), 35'(10'b0));
    chk("mr_olck",    35'(OLCK), 35'(10'b0));
    chk("mr_ordy0",   35'(ORDY), 35'(10'b0));
`ifdef ROUTER_ERR_EN
    chk("mr_err",     35'(ERR), 35'(5'b0));
`endif
    RST_ = 1'b0; IVALID = '0; tick();
    chk("mr_ordy1",   35'(ORDY), 35'(10'h3ff));
    chk("mr_notail1", 35'(OVALID), 35'(5'b0));
    tick();
    chk("mr_notail2", 35'(OVALID), 35'(5'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
